// File: rtl/board_state_mgr_if.sv
// Bundle between the key/display side and the board state manager.
// The manager takes the slave view; the key pulses and display read address come from the master.
interface board_state_mgr_if #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned PIECE_W = 4
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic               new_game;
    logic               up;
    logic               down;
    logic               left;
    logic               right;
    logic               sel;
    logic               cancel;
    logic               time_up;
    logic [RW-1:0]      rd_row;
    logic [CW-1:0]      rd_col;
    logic [PIECE_W-1:0] rd_piece;
    logic [RW-1:0]      cur_row;
    logic [CW-1:0]      cur_col;
    logic               src_valid;
    logic [RW-1:0]      src_row;
    logic [CW-1:0]      src_col;
    logic               turn;
    logic               move_done;
    logic               capture;
    logic [15:0]        move_count;
    logic               game_over;

    modport slave (
        input  new_game, up, down, left, right, sel, cancel, time_up, rd_row, rd_col,
        output rd_piece, cur_row, cur_col, src_valid, src_row, src_col, turn, move_done,
               capture, move_count, game_over
    );

    modport master (
        output new_game, up, down, left, right, sel, cancel, time_up, rd_row, rd_col,
        input  rd_piece, cur_row, cur_col, src_valid, src_row, src_col, turn, move_done,
               capture, move_count, game_over
    );
endinterface

// File: rtl/board_state_mgr.sv
// Chess board register file with cursor-driven move entry, turn tracking and game-over freeze.
// Square codes: 0-5 black, 6-11 white (king 4/10), EMPTY for a vacant square.
module board_state_mgr #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned PIECE_W = 4,
    parameter int unsigned EMPTY   = 15,
    parameter bit          WRAP    = 1'b1
) (
    input logic              clk,
    input logic              reset_n,
    board_state_mgr_if.slave bus
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0]      RowMax    = RW'(ROWS - 1);
    localparam logic [CW-1:0]      ColMax    = CW'(COLS - 1);
    localparam logic [PIECE_W-1:0] EmptyCode = PIECE_W'(EMPTY);
    localparam logic [PIECE_W-1:0] KingB     = PIECE_W'(4);
    localparam logic [PIECE_W-1:0] KingW     = PIECE_W'(10);

    typedef enum logic [1:0] {StPickSrc, StPickDst, StCommit, StFrozen} state_e;

    function automatic logic [PIECE_W-1:0] start_code(int unsigned r, int unsigned c);
        int unsigned back;
        case (c % 8)
            0, 7:    back = 0;
            1, 6:    back = 1;
            2, 5:    back = 2;
            3:       back = 3;
            default: back = 4;
        endcase
        if (r == 0)             return PIECE_W'(back);
        else if (r == 1)        return PIECE_W'(5);
        else if (r == ROWS - 2) return PIECE_W'(11);
        else if (r == ROWS - 1) return PIECE_W'(back + 6);
        else                    return EmptyCode;
    endfunction

    // Colour of the side to move: turn 0 owns the white codes, turn 1 the black codes.
    function automatic logic is_own(logic [PIECE_W-1:0] code, logic side);
        logic white;
        logic black;
        black = (code <= PIECE_W'(5));
        white = (code >= PIECE_W'(6)) && (code <= PIECE_W'(11));
        return side ? black : white;
    endfunction

    logic [PIECE_W-1:0] board_q [ROWS][COLS];
    state_e             state_q, state_d;
    logic [RW-1:0]      cur_row_q, cur_row_d, src_row_q, src_row_d, dst_row_q, dst_row_d;
    logic [CW-1:0]      cur_col_q, cur_col_d, src_col_q, src_col_d, dst_col_q, dst_col_d;
    logic               src_valid_q, src_valid_d;
    logic               turn_q, turn_d;
    logic [15:0]        move_count_q, move_count_d;
    logic               game_over_q, game_over_d;
    logic               load_start, commit_wr;
    logic [PIECE_W-1:0] cur_piece, dst_piece;
    logic               at_src;

    assign cur_piece = board_q[cur_row_q][cur_col_q];
    assign dst_piece = board_q[dst_row_q][dst_col_q];
    assign at_src    = (cur_row_q == src_row_q) && (cur_col_q == src_col_q);

    always_comb begin
        state_d      = state_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        src_valid_d  = src_valid_q;
        src_row_d    = src_row_q;
        src_col_d    = src_col_q;
        dst_row_d    = dst_row_q;
        dst_col_d    = dst_col_q;
        turn_d       = turn_q;
        move_count_d = move_count_q;
        game_over_d  = game_over_q;
        load_start   = 1'b0;
        commit_wr    = 1'b0;

        unique case (state_q)
            StPickSrc: begin
                if (bus.sel && is_own(cur_piece, turn_q)) begin
                    src_valid_d = 1'b1;
                    src_row_d   = cur_row_q;
                    src_col_d   = cur_col_q;
                    state_d     = StPickDst;
                end
            end
            StPickDst: begin
                if (bus.cancel || (bus.sel && at_src)) begin
                    src_valid_d = 1'b0;
                    state_d     = StPickSrc;
                end else if (bus.sel && is_own(cur_piece, turn_q)) begin
                    src_row_d = cur_row_q;
                    src_col_d = cur_col_q;
                end else if (bus.sel) begin
                    dst_row_d = cur_row_q;
                    dst_col_d = cur_col_q;
                    state_d   = StCommit;
                end
            end
            StCommit: begin
                commit_wr   = 1'b1;
                src_valid_d = 1'b0;
                turn_d      = ~turn_q;
                if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
                if (dst_piece == KingB || dst_piece == KingW) begin
                    game_over_d = 1'b1;
                    state_d     = StFrozen;
                end else begin
                    state_d = StPickSrc;
                end
            end
            StFrozen: ;
            default: state_d = StPickSrc;
        endcase

        // Cursor runs in parallel with selection; sel above used the pre-update position.
        if (state_q != StFrozen) begin
            if (bus.up && !bus.down) begin
                cur_row_d = (cur_row_q == '0) ? (WRAP ? RowMax : cur_row_q) : cur_row_q - 1'b1;
            end else if (bus.down && !bus.up) begin
                cur_row_d = (cur_row_q == RowMax) ? (WRAP ? '0 : cur_row_q) : cur_row_q + 1'b1;
            end
            if (bus.left && !bus.right) begin
                cur_col_d = (cur_col_q == '0) ? (WRAP ? ColMax : cur_col_q) : cur_col_q - 1'b1;
            end else if (bus.right && !bus.left) begin
                cur_col_d = (cur_col_q == ColMax) ? (WRAP ? '0 : cur_col_q) : cur_col_q + 1'b1;
            end
        end

        // A move already in COMMIT still lands; any pending selection is dropped.
        if (bus.time_up) begin
            state_d     = StFrozen;
            src_valid_d = 1'b0;
            src_row_d   = src_row_q;
            src_col_d   = src_col_q;
            dst_row_d   = dst_row_q;
            dst_col_d   = dst_col_q;
            game_over_d = 1'b1;
        end

        if (bus.new_game) begin
            state_d      = StPickSrc;
            cur_row_d    = '0;
            cur_col_d    = '0;
            src_valid_d  = 1'b0;
            turn_d       = 1'b0;
            move_count_d = '0;
            game_over_d  = 1'b0;
            load_start   = 1'b1;
            commit_wr    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StPickSrc;
            cur_row_q    <= '0;
            cur_col_q    <= '0;
            src_valid_q  <= 1'b0;
            src_row_q    <= '0;
            src_col_q    <= '0;
            dst_row_q    <= '0;
            dst_col_q    <= '0;
            turn_q       <= 1'b0;
            move_count_q <= '0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_row_q    <= cur_row_d;
            cur_col_q    <= cur_col_d;
            src_valid_q  <= src_valid_d;
            src_row_q    <= src_row_d;
            src_col_q    <= src_col_d;
            dst_row_q    <= dst_row_d;
            dst_col_q    <= dst_col_d;
            turn_q       <= turn_d;
            move_count_q <= move_count_d;
            game_over_q  <= game_over_d;
        end
    end

    // Source and destination always differ: selecting the source square cancels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) board_q[r][c] <= start_code(r, c);
        end else if (load_start) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) board_q[r][c] <= start_code(r, c);
        end else if (commit_wr) begin
            board_q[dst_row_q][dst_col_q] <= board_q[src_row_q][src_col_q];
            board_q[src_row_q][src_col_q] <= EmptyCode;
        end
    end

    assign bus.rd_piece   = board_q[bus.rd_row][bus.rd_col];
    assign bus.cur_row    = cur_row_q;
    assign bus.cur_col    = cur_col_q;
    assign bus.src_valid  = src_valid_q;
    assign bus.src_row    = src_row_q;
    assign bus.src_col    = src_col_q;
    assign bus.turn       = turn_q;
    assign bus.move_done  = (state_q == StCommit);
    assign bus.capture    = (state_q == StCommit) && (dst_piece != EmptyCode);
    assign bus.move_count = move_count_q;
    assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_board_state_mgr.sv
// Bench for board_state_mgr: directed move-entry scenarios plus a randomized key stream
// compared every cycle against a square-by-square chess-board model.
module tb_board_state_mgr;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    board_state_mgr_if #(.ROWS(8), .COLS(8), .PIECE_W(4)) bif ();
    board_state_mgr_if #(.ROWS(8), .COLS(8), .PIECE_W(4)) bif0 ();

    board_state_mgr #(.ROWS(8), .COLS(8), .PIECE_W(4), .EMPTY(15), .WRAP(1'b1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    board_state_mgr #(.ROWS(8), .COLS(8), .PIECE_W(4), .EMPTY(15), .WRAP(1'b0)) u_dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif0)
    );

    // Reference model state
    int mb [8][8];
    int m_r, m_c, m_srcv, m_sr, m_sc, m_turn, m_cnt, m_over, m_commit, m_dr, m_dc;

    function automatic int exp_start(int r, int c);
        int back [8];
        back = '{0, 1, 2, 3, 4, 2, 1, 0};
        if (r == 0) return back[c];
        if (r == 1) return 5;
        if (r == 6) return 11;
        if (r == 7) return back[c] + 6;
        return 15;
    endfunction

    function automatic bit m_own(int code, int side);
        if (side == 0) return (code >= 6 && code <= 11);
        return (code >= 0 && code <= 5);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mb[r][c] = exp_start(r, c);
        m_r = 0; m_c = 0; m_srcv = 0; m_sr = 0; m_sc = 0; m_turn = 0; m_cnt = 0;
        m_over = 0; m_commit = 0; m_dr = 0; m_dc = 0;
    endtask

    task automatic model_step(input bit ng, u, dn, l, rt, s, cn, tu);
        bit king;
        if (ng) begin
            model_reset();
            return;
        end
        if (m_over) return;
        if (m_commit) begin
            king = (mb[m_dr][m_dc] == 4 || mb[m_dr][m_dc] == 10);
            mb[m_dr][m_dc] = mb[m_sr][m_sc];
            mb[m_sr][m_sc] = 15;
            m_commit = 0;
            m_srcv = 0;
            m_turn = 1 - m_turn;
            if (m_cnt < 65535) m_cnt++;
            if (king) m_over = 1;
        end else if (!tu) begin
            if (!m_srcv) begin
                if (s && m_own(mb[m_r][m_c], m_turn)) begin
                    m_srcv = 1; m_sr = m_r; m_sc = m_c;
                end
            end else if (cn) begin
                m_srcv = 0;
            end else if (s) begin
                if (m_r == m_sr && m_c == m_sc) m_srcv = 0;
                else if (m_own(mb[m_r][m_c], m_turn)) begin
                    m_sr = m_r; m_sc = m_c;
                end else begin
                    m_commit = 1; m_dr = m_r; m_dc = m_c;
                end
            end
        end
        if (tu) begin
            m_over = 1; m_srcv = 0; m_commit = 0;
        end
        if (u && !dn) m_r = (m_r + 7) % 8;
        if (dn && !u) m_r = (m_r + 1) % 8;
        if (l && !rt) m_c = (m_c + 7) % 8;
        if (rt && !l) m_c = (m_c + 1) % 8;
    endtask

    // Called right after a falling edge: holds the inputs across one rising edge.
    task automatic step(input bit ng, u, dn, l, rt, s, cn, tu);
        bif.new_game = ng; bif.up = u; bif.down = dn; bif.left = l; bif.right = rt;
        bif.sel = s; bif.cancel = cn; bif.time_up = tu;
        @(negedge clk);
        bif.new_game = 0; bif.up = 0; bif.down = 0; bif.left = 0; bif.right = 0;
        bif.sel = 0; bif.cancel = 0; bif.time_up = 0;
    endtask

    task automatic move_cur(input int dr, input int dc);
        for (int i = 0; i < (dr < 0 ? -dr : dr); i++) step(0, dr < 0, dr > 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < (dc < 0 ? -dc : dc); i++) step(0, 0, 0, dc < 0, dc > 0, 0, 0, 0);
    endtask

    task automatic check_start_board(input string tag);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                bif.rd_row = 3'(r); bif.rd_col = 3'(c);
                #1;
                n_total++;
                if (bif.rd_piece !== 4'(exp_start(r, c)))
                    $display("FAIL %s sq(%0d,%0d): got %0d expected %0d", tag, r, c,
                             bif.rd_piece, exp_start(r, c));
                else n_pass++;
            end
        @(negedge clk);
    endtask

    task automatic check_sq(input int r, input int c, input int exp, input string tag);
        bif.rd_row = 3'(r); bif.rd_col = 3'(c);
        #1;
        n_total++;
        if (bif.rd_piece !== 4'(exp))
            $display("FAIL %s sq(%0d,%0d): got %0d expected %0d", tag, r, c, bif.rd_piece, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if ({bif.cur_row, bif.cur_col, bif.src_valid, bif.turn, bif.move_done, bif.capture,
             bif.game_over} !== 11'b0)
            $display("FAIL reset_flags: got cur=(%0d,%0d) sv=%b t=%b md=%b cap=%b go=%b expected zeros",
                     bif.cur_row, bif.cur_col, bif.src_valid, bif.turn, bif.move_done,
                     bif.capture, bif.game_over);
        else n_pass++;
        n_total++;
        if (bif.move_count !== 16'd0)
            $display("FAIL reset_count: got %0d expected 0", bif.move_count);
        else n_pass++;
        check_start_board("reset_board");
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_move_wrap();
        move_cur(6, 4);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.src_valid !== 1'b1 || bif.src_row !== 3'd6 || bif.src_col !== 3'd4)
            $display("FAIL move_src: got sv=%b (%0d,%0d) expected 1 (6,4)", bif.src_valid,
                     bif.src_row, bif.src_col);
        else n_pass++;
        move_cur(2, 0);
        n_total++;
        if (bif.cur_row !== 3'd0) $display("FAIL wrap_down: got %0d expected 0", bif.cur_row);
        else n_pass++;
        move_cur(-4, 0);
        n_total++;
        if (bif.cur_row !== 3'd4 || bif.cur_col !== 3'd4)
            $display("FAIL wrap_up: got (%0d,%0d) expected (4,4)", bif.cur_row, bif.cur_col);
        else n_pass++;
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.move_done !== 1'b1 || bif.capture !== 1'b0)
            $display("FAIL move_pulse: got md=%b cap=%b expected md=1 cap=0", bif.move_done,
                     bif.capture);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (bif.turn !== 1'b1 || bif.move_count !== 16'd1 || bif.src_valid !== 1'b0 ||
            bif.move_done !== 1'b0)
            $display("FAIL move_after: got t=%b cnt=%0d sv=%b md=%b expected 1 1 0 0", bif.turn,
                     bif.move_count, bif.src_valid, bif.move_done);
        else n_pass++;
        check_sq(4, 4, 11, "move_dst");
        check_sq(6, 4, 15, "move_src_empty");
        @(negedge clk);
    endtask

    task automatic test_src_ignore();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        move_cur(1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.src_valid !== 1'b0 || bif.turn !== 1'b0)
            $display("FAIL sel_opponent: got sv=%b t=%b expected 0 0", bif.src_valid, bif.turn);
        else n_pass++;
        move_cur(2, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.src_valid !== 1'b0) $display("FAIL sel_empty: got %b expected 0", bif.src_valid);
        else n_pass++;
    endtask

    task automatic test_saturate();
        bif0.up = 1'b1; bif0.left = 1'b1;
        @(negedge clk);
        bif0.up = 1'b0; bif0.left = 1'b0;
        n_total++;
        if (bif0.cur_row !== 3'd0 || bif0.cur_col !== 3'd0)
            $display("FAIL sat_low: got (%0d,%0d) expected (0,0)", bif0.cur_row, bif0.cur_col);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            bif0.down = 1'b1; bif0.right = 1'b1;
            @(negedge clk);
            bif0.down = 1'b0; bif0.right = 1'b0;
        end
        n_total++;
        if (bif0.cur_row !== 3'd7 || bif0.cur_col !== 3'd7)
            $display("FAIL sat_high: got (%0d,%0d) expected (7,7)", bif0.cur_row, bif0.cur_col);
        else n_pass++;
    endtask

    task automatic test_king_capture();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        move_cur(6, 4);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        move_cur(-6, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.move_done !== 1'b1 || bif.capture !== 1'b1)
            $display("FAIL king_pulse: got md=%b cap=%b expected 1 1", bif.move_done, bif.capture);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (bif.game_over !== 1'b1 || bif.move_count !== 16'd1)
            $display("FAIL king_over: got go=%b cnt=%0d expected 1 1", bif.game_over,
                     bif.move_count);
        else n_pass++;
        check_sq(0, 4, 11, "king_dst");
        @(negedge clk);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.cur_row !== 3'd0 || bif.cur_col !== 3'd4 || bif.src_valid !== 1'b0)
            $display("FAIL frozen_ignore: got (%0d,%0d) sv=%b expected (0,4) 0", bif.cur_row,
                     bif.cur_col, bif.src_valid);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        n_total++;
        if (bif.game_over !== 1'b0 || bif.move_count !== 16'd0 || bif.turn !== 1'b0)
            $display("FAIL new_game: got go=%b cnt=%0d t=%b expected 0 0 0", bif.game_over,
                     bif.move_count, bif.turn);
        else n_pass++;
        check_start_board("new_game_board");
    endtask

    task automatic test_time_up();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        move_cur(6, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        n_total++;
        if (bif.src_valid !== 1'b0 || bif.game_over !== 1'b1)
            $display("FAIL time_up: got sv=%b go=%b expected 0 1", bif.src_valid, bif.game_over);
        else n_pass++;
        check_sq(6, 0, 11, "time_up_board");
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.src_valid !== 1'b0 || bif.move_done !== 1'b0)
            $display("FAIL time_up_sel: got sv=%b md=%b expected 0 0", bif.src_valid,
                     bif.move_done);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        move_cur(6, 0);
        step(0, 1, 1, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.src_valid !== 1'b1 || bif.src_row !== 3'd6 || bif.src_col !== 3'd0 ||
            bif.cur_row !== 3'd6)
            $display("FAIL same_cycle: got sv=%b src=(%0d,%0d) row=%0d expected 1 (6,0) 6",
                     bif.src_valid, bif.src_row, bif.src_col, bif.cur_row);
        else n_pass++;
        step(0, 0, 0, 1, 1, 0, 0, 0);
        n_total++;
        if (bif.cur_col !== 3'd0) $display("FAIL left_right: got %0d expected 0", bif.cur_col);
        else n_pass++;
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        move_cur(-4, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (bif.turn !== 1'b1 || bif.src_valid !== 1'b1 || bif.move_count !== 16'd1)
            $display("FAIL black_src: got t=%b sv=%b cnt=%0d expected 1 1 1", bif.turn,
                     bif.src_valid, bif.move_count);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (bif.src_valid !== 1'b0 || bif.turn !== 1'b0 || bif.move_count !== 16'd0 ||
            bif.cur_row !== 3'd0 || bif.cur_col !== 3'd0 || bif.game_over !== 1'b0)
            $display("FAIL async_reset: got sv=%b t=%b cnt=%0d cur=(%0d,%0d) go=%b expected zeros",
                     bif.src_valid, bif.turn, bif.move_count, bif.cur_row, bif.cur_col,
                     bif.game_over);
        else n_pass++;
        check_sq(6, 0, 11, "reset_restore");
        check_sq(5, 0, 15, "reset_clear");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ng, u, dn, l, rt, s, cn, tu;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 600; i++) begin
            ng = ($urandom_range(0, 89) == 0);
            tu = ($urandom_range(0, 199) == 0);
            u  = ($urandom_range(0, 3) == 0);
            dn = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 3) == 0);
            rt = ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 2) == 0);
            cn = ($urandom_range(0, 11) == 0);
            step(ng, u, dn, l, rt, s, cn, tu);
            model_step(ng, u, dn, l, rt, s, cn, tu);
            bif.rd_row = 3'($urandom_range(0, 7));
            bif.rd_col = 3'($urandom_range(0, 7));
            #1;
            n_total++;
            if (bif.cur_row !== 3'(m_r) || bif.cur_col !== 3'(m_c))
                $display("FAIL rnd_cursor @%0d: got (%0d,%0d) expected (%0d,%0d)", i, bif.cur_row,
                         bif.cur_col, m_r, m_c);
            else n_pass++;
            n_total++;
            if (bif.src_valid !== 1'(m_srcv) ||
                (m_srcv == 1 && (bif.src_row !== 3'(m_sr) || bif.src_col !== 3'(m_sc))))
                $display("FAIL rnd_src @%0d: got %b (%0d,%0d) expected %0d (%0d,%0d)", i,
                         bif.src_valid, bif.src_row, bif.src_col, m_srcv, m_sr, m_sc);
            else n_pass++;
            n_total++;
            if (bif.turn !== 1'(m_turn) || bif.move_count !== 16'(m_cnt) ||
                bif.game_over !== 1'(m_over))
                $display("FAIL rnd_game @%0d: got t=%b cnt=%0d go=%b expected %0d %0d %0d", i,
                         bif.turn, bif.move_count, bif.game_over, m_turn, m_cnt, m_over);
            else n_pass++;
            n_total++;
            if (bif.move_done !== 1'(m_commit) ||
                bif.capture !== 1'(m_commit == 1 && mb[m_dr][m_dc] != 15))
                $display("FAIL rnd_pulse @%0d: got md=%b cap=%b expected md=%0d", i,
                         bif.move_done, bif.capture, m_commit);
            else n_pass++;
            n_total++;
            if (bif.rd_piece !== 4'(mb[bif.rd_row][bif.rd_col]))
                $display("FAIL rnd_board @%0d sq(%0d,%0d): got %0d expected %0d", i, bif.rd_row,
                         bif.rd_col, bif.rd_piece, mb[bif.rd_row][bif.rd_col]);
            else n_pass++;
        end
    endtask

    initial begin
        bif.new_game = 0; bif.up = 0; bif.down = 0; bif.left = 0; bif.right = 0;
        bif.sel = 0; bif.cancel = 0; bif.time_up = 0; bif.rd_row = '0; bif.rd_col = '0;
        bif0.new_game = 0; bif0.up = 0; bif0.down = 0; bif0.left = 0; bif0.right = 0;
        bif0.sel = 0; bif0.cancel = 0; bif0.time_up = 0; bif0.rd_row = '0; bif0.rd_col = '0;
        test_reset();
        test_move_wrap();
        test_src_ignore();
        test_saturate();
        test_king_capture();
        test_time_up();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
